// File: rtl/mc14500b_clock_ctrl.sv
// Clock-enable controller for the MC14500B demo core: one-cycle TICK enables
// in run, single-step and burst modes, with core-requested halt and resume.
module mc14500b_clock_ctrl #(
  parameter int CNT_WIDTH   = 20,
  parameter int COUNT_WIDTH = 16,
  parameter int BURST_LEN   = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             MODE,
  input  logic [CNT_WIDTH-1:0]   DIV,
  input  logic                   STEP,
  input  logic                   HALT_REQ,
  input  logic                   RESUME,
  output logic                   TICK,
  output logic                   PHASE,
  output logic [2:0]             STATE,
  output logic [COUNT_WIDTH-1:0] TICK_COUNT
);

  // state | meaning
  // IDLE   | no ticks, decode MODE to pick the next activity
  // RUN    | free-running ticks every DIV+1 cycles
  // STEP   | one tick per STEP pulse
  // BURST  | divided ticks until BURST_LEN have been issued
  // DONE   | burst finished, waits for MODE to leave 11
  // HALTED | core asked to stop; waits for RESUME or MODE 00
  localparam int BW = (BURST_LEN < 1) ? 1 : $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_BURST  = 3'd3,
    S_DONE   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic                 tick_d;
  logic                 wrap;

  assign wrap  = (cnt_q == div_q);
  assign STATE = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    burst_d = burst_q;
    tick_d  = 1'b0;
    if (HALT_REQ && state_q != S_HALTED) begin
      state_d = S_HALTED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          case (MODE)
            2'b01: begin
              state_d = S_RUN;
              div_d   = DIV;
            end
            2'b10: state_d = S_STEP;
            2'b11: begin
              state_d = S_BURST;
              div_d   = DIV;
              burst_d = BW'(BURST_LEN);
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_RUN: begin
          if (MODE != 2'b01) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (wrap) begin
            // DIV is only re-sampled at a wrap so a period is never cut short
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = DIV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STEP: begin
          if (MODE != 2'b10) state_d = S_IDLE;
          else               tick_d  = STEP;
        end
        S_BURST: begin
          if (MODE != 2'b11) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (burst_q == '0) begin
            state_d = S_DONE;
          end else if (wrap) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            div_d   = DIV;
            burst_d = burst_q - 1'b1;
            if (burst_q == BW'(1)) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (MODE != 2'b11) state_d = S_IDLE;
        end
        S_HALTED: begin
          if (!HALT_REQ && (RESUME || MODE == 2'b00)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      burst_q    <= '0;
      TICK       <= 1'b0;
      PHASE      <= 1'b1;
      TICK_COUNT <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      TICK    <= tick_d;
      if (tick_d) begin
        PHASE      <= ~PHASE;
        TICK_COUNT <= TICK_COUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc14500b_clock_ctrl.sv
// Bench for mc14500b_clock_ctrl: directed scenarios plus a randomized run
// checked against a timestamp-based reference model.
module tb_mc14500b_clock_ctrl;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int BL = 5;

  logic          clk = 1'b0;
  logic          rst, step, halt_req, resume;
  logic [1:0]    mode;
  logic [CW-1:0] div;
  logic          tick, phase, tick0, phase0;
  logic [2:0]    state, state0;
  logic [NW-1:0] tick_count, tick_count0;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // reference model: absolute cycle at which the next divided tick is due
  int m_st, m_due, m_left, m_tick, m_phase, m_cnt;

  mc14500b_clock_ctrl #(.CNT_WIDTH(CW), .COUNT_WIDTH(NW), .BURST_LEN(BL)) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .DIV(div), .STEP(step),
    .HALT_REQ(halt_req), .RESUME(resume), .TICK(tick), .PHASE(phase),
    .STATE(state), .TICK_COUNT(tick_count));

  mc14500b_clock_ctrl #(.CNT_WIDTH(CW), .COUNT_WIDTH(NW), .BURST_LEN(0)) dut0 (
    .CLK(clk), .RST(rst), .MODE(mode), .DIV(div), .STEP(step),
    .HALT_REQ(halt_req), .RESUME(resume), .TICK(tick0), .PHASE(phase0),
    .STATE(state0), .TICK_COUNT(tick_count0));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    if (rst) begin
      m_st = 0; m_tick = 0; m_phase = 1; m_cnt = 0; m_left = 0;
    end else begin
      m_tick = 0;
      if (halt_req && m_st != 5) m_st = 5;
      else case (m_st)
        0: if (mode == 1) begin m_st = 1; m_due = cyc_n + int'(div) + 1; end
           else if (mode == 2) m_st = 2;
           else if (mode == 3) begin m_st = 3; m_left = BL; m_due = cyc_n + int'(div) + 1; end
        1: if (mode != 1) m_st = 0;
           else if (cyc_n == m_due) begin m_tick = 1; m_due = cyc_n + int'(div) + 1; end
        2: if (mode != 2) m_st = 0; else m_tick = int'(step);
        3: if (mode != 3) m_st = 0;
           else if (m_left == 0) m_st = 4;
           else if (cyc_n == m_due) begin
             m_tick = 1; m_left--; m_due = cyc_n + int'(div) + 1;
             if (m_left == 0) m_st = 4;
           end
        4: if (mode != 3) m_st = 0;
        5: if (!halt_req && (resume || mode == 0)) m_st = 0;
        default: m_st = 0;
      endcase
      if (m_tick != 0) begin m_phase ^= 1; m_cnt = (m_cnt + 1) % (1 << NW); end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; mode = 2'b01; div = 8'd3; step = 0; halt_req = 0; resume = 0;
    cyc(); cyc();
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", tick); end
    tests++; if (phase !== 1'b1) begin fails++; $display("FAIL reset_phase got %b want 1", phase); end
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (tick_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", tick_count); end
    rst = 0;
    cyc();
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL reset_to_run got %0d want 1", state); end
  endtask

  task automatic test_run();
    logic want;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      want = (i % 4 == 0);
      tests++; if (tick !== want) begin fails++; $display("FAIL run_tick cyc %0d got %b want %b", i, tick, want); end
      tests++; if (phase !== 1'(1 ^ ((i / 4) % 2))) begin fails++; $display("FAIL run_phase cyc %0d got %b", i, phase); end
    end
    tests++; if (tick_count !== 4'd3) begin fails++; $display("FAIL run_count got %0d want 3", tick_count); end
    cyc();
    div = 8'd0;
    for (int i = 14; i <= 20; i++) begin
      cyc();
      want = (i >= 16);
      tests++; if (tick !== want) begin fails++; $display("FAIL run_div_change cyc %0d got %b want %b", i, tick, want); end
    end
    tests++; if (tick_count !== 4'd8) begin fails++; $display("FAIL run_count2 got %0d want 8", tick_count); end
  endtask

  task automatic test_step();
    logic want;
    logic [NW-1:0] base;
    mode = 2'b10;
    cyc();
    tests++; if (tick !== 1'b0 || state !== 3'd0) begin fails++; $display("FAIL run_exit tick %b state %0d want 0/0", tick, state); end
    cyc();
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL step_enter got %0d want 2", state); end
    base = tick_count;
    for (int i = 1; i <= 25; i++) begin
      step = ((i - 1) == 10 || (i - 1) == 20 || (i - 1) == 21);
      cyc();
      want = (i == 11 || i == 21 || i == 22);
      tests++; if (tick !== want) begin fails++; $display("FAIL step_tick cyc %0d got %b want %b", i, tick, want); end
    end
    tests++; if (tick_count !== base + 4'd3) begin fails++; $display("FAIL step_count got %0d want %0d", tick_count, base + 4'd3); end
    step = 1; mode = 2'b00;
    cyc();
    step = 0;
    tests++; if (tick !== 1'b0 || state !== 3'd0) begin fails++; $display("FAIL step_mode_change tick %b state %0d want 0/0", tick, state); end
  endtask

  task automatic test_burst();
    logic want;
    int n;
    div = 8'd1; mode = 2'b11;
    cyc();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL burst_enter got %0d want 3", state); end
    for (int i = 1; i <= 14; i++) begin
      cyc();
      want = (i % 2 == 0 && i <= 10);
      tests++; if (tick !== want) begin fails++; $display("FAIL burst_tick cyc %0d got %b want %b", i, tick, want); end
      tests++; if (state !== ((i >= 10) ? 3'd4 : 3'd3)) begin fails++; $display("FAIL burst_state cyc %0d got %0d", i, state); end
    end
    mode = 2'b00; cyc();
    mode = 2'b11; cyc();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL burst_rearm got %0d want 3", state); end
    n = 0;
    for (int i = 1; i <= 14; i++) begin cyc(); n += int'(tick); end
    tests++; if (n != BL || state !== 3'd4) begin fails++; $display("FAIL burst_second ticks %0d state %0d want %0d/4", n, state, BL); end
  endtask

  task automatic test_burst_zero();
    logic [NW-1:0] base;
    mode = 2'b00; cyc();
    base = tick_count0;
    mode = 2'b11; cyc();
    tests++; if (state0 !== 3'd3) begin fails++; $display("FAIL bz_enter got %0d want 3", state0); end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      tests++; if (state0 !== 3'd4 || tick0 !== 1'b0) begin fails++; $display("FAIL bz_done cyc %0d state %0d tick %b want 4/0", i, state0, tick0); end
    end
    tests++; if (tick_count0 !== base) begin fails++; $display("FAIL bz_count got %0d want %0d", tick_count0, base); end
  endtask

  task automatic test_halt();
    logic want;
    mode = 2'b00; cyc();
    div = 8'd3; mode = 2'b01; cyc();
    for (int i = 1; i <= 3; i++) cyc();
    halt_req = 1; cyc();
    tests++; if (tick !== 1'b0 || state !== 3'd5) begin fails++; $display("FAIL halt_enter tick %b state %0d want 0/5", tick, state); end
    resume = 1; cyc();
    tests++; if (state !== 3'd5) begin fails++; $display("FAIL halt_resume_ignored got %0d want 5", state); end
    resume = 0; halt_req = 0; cyc();
    tests++; if (state !== 3'd5) begin fails++; $display("FAIL halt_hold got %0d want 5", state); end
    resume = 1; cyc();
    resume = 0;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL halt_exit got %0d want 0", state); end
    cyc();
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL halt_rerun got %0d want 1", state); end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      want = (i == 4 || i == 8);
      tests++; if (tick !== want) begin fails++; $display("FAIL halt_rerun_tick cyc %0d got %b want %b", i, tick, want); end
    end
  endtask

  task automatic test_wrap();
    logic want;
    rst = 1; mode = 2'b01; div = 8'd0; cyc();
    rst = 0; cyc();
    for (int i = 1; i <= 17; i++) cyc();
    tests++; if (tick_count !== 4'd1 || phase !== 1'b0) begin fails++; $display("FAIL wrap_count cnt %0d phase %b want 1/0", tick_count, phase); end
    div = 8'd3; cyc(); cyc();
    rst = 1; cyc();
    tests++; if (tick_count !== 4'd0 || phase !== 1'b1 || state !== 3'd0 || tick !== 1'b0) begin
      fails++; $display("FAIL wrap_reset cnt %0d phase %b state %0d tick %b want 0/1/0/0", tick_count, phase, state, tick);
    end
    rst = 0; cyc();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      want = (i == 4);
      tests++; if (tick !== want) begin fails++; $display("FAIL wrap_restart cyc %0d got %b want %b", i, tick, want); end
    end
  endtask

  task automatic test_random();
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) div = CW'($urandom_range(0, 4));
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) halt_req = ~halt_req;
      resume = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
      tests++;
      if (tick !== (m_tick != 0) || phase !== (m_phase != 0) || state !== 3'(m_st) || tick_count !== NW'(m_cnt)) begin
        fails++;
        $display("FAIL random cyc %0d tick/phase/state/cnt got %b/%b/%0d/%0d want %0d/%0d/%0d/%0d",
                 i, tick, phase, state, tick_count, m_tick, m_phase, m_st, m_cnt);
      end
    end
    rst = 0; step = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    m_st = 0; m_due = 0; m_left = 0; m_tick = 0; m_phase = 1; m_cnt = 0;
    test_reset();
    test_run();
    test_step();
    test_burst();
    test_burst_zero();
    test_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
